// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding, SPI command codes and word-count saturation helper
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SETUP,
      SEND,
      WAIT_RX,
      WAIT_RDY,
      HOLD
   } state_t;

   localparam logic [7:0] CMD_WRITE_VALS   = 8'h01;
   localparam logic [7:0] CMD_READ_VALS    = 8'h02;
   localparam logic [7:0] CMD_CHECK_DONE   = 8'h03;
   localparam logic [7:0] CMD_READ_RESULT1 = 8'h04;
   localparam logic [7:0] CMD_READ_RESULT2 = 8'h05;

   function automatic logic [4:0] sat_words(input logic [4:0] n, input logic [4:0] max_n);
      return (n > max_n) ? max_n : n;
   endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// spi_seq_timer: loadable down-counter that flags zero, used to time slave-select setup and hold
module spi_seq_timer #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] cnt_q, cnt_d;

   // load takes priority; otherwise count down and stick at zero
   always_comb cnt_d = i_load ? i_load_val : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);

   // counter register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;

   assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/spi_host_seq.sv
// spi_host_seq: sequences a command byte plus LSB-first 32-bit words, each byte framed by its own slave-select pulse
module spi_host_seq
   import spi_pkg::*;
#(
   parameter int CS_SETUP_CYC = 10,
   parameter int CS_HOLD_CYC  = 10,
   parameter int MAX_WORDS    = 20
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_cmd,
   input  logic [4:0]  i_num_words,
   input  logic        i_tx_words,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [31:0] i_wdata,
   input  logic        i_wdata_valid,
   output logic        o_wdata_ready,
   output logic [31:0] o_rdata,
   output logic        o_rdata_valid,
   output logic [7:0]  o_status,
   output logic        o_done,
   output logic        o_busy,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_ss_n
);

   localparam logic [4:0]  MAX_W    = 5'(MAX_WORDS);
   localparam logic [15:0] SETUP_LD = 16'(CS_SETUP_CYC - 1);
   localparam logic [15:0] HOLD_LD  = 16'(CS_HOLD_CYC - 1);

   state_t      state_q, state_d;
   logic [7:0]  cmd_q, status_q;
   logic        tx_words_q, in_cmd_q, busy_q, done_q, rdata_valid_q, ss_n_q, ss_n_d;
   logic [4:0]  nwords_q, word_q;
   logic [1:0]  byte_q;
   logic [31:0] wdata_q, rdata_q;
   logic [23:0] rx_sh_q;
   logic        tmr_zero, tmr_load, last_byte, next_fetch;
   logic [15:0] tmr_val;

   assign last_byte  = in_cmd_q ? (nwords_q == 5'd0) : (byte_q == 2'd3 && word_q == nwords_q - 5'd1);
   assign next_fetch = tx_words_q && (in_cmd_q || byte_q == 2'd3);
   assign tmr_load   = (state_d == SETUP && state_q != SETUP) || (state_d == HOLD && state_q != HOLD);
   assign tmr_val    = (state_d == HOLD) ? HOLD_LD : SETUP_LD;
   assign ss_n_d     = !(state_d inside {SETUP, SEND, WAIT_RX, WAIT_RDY});

   spi_seq_timer #(.W(16)) u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (tmr_load),
      .i_load_val (tmr_val),
      .o_zero     (tmr_zero)
   );

   // next-state logic: one framed byte per SETUP..HOLD loop
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (i_cmd_valid) state_d = SETUP;
         FETCH:    if (i_wdata_valid) state_d = SETUP;
         SETUP:    if (tmr_zero) state_d = SEND;
         SEND:     if (i_tx_ready) state_d = WAIT_RX;
         WAIT_RX:  if (i_rx_valid) state_d = WAIT_RDY;
         WAIT_RDY: if (i_tx_ready) state_d = HOLD;
         HOLD:     if (tmr_zero) state_d = last_byte ? IDLE : (next_fetch ? FETCH : SETUP);
         default:  state_d = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;

   // transaction context, byte/word counters and receive assembly
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cmd_q         <= '0;
         tx_words_q    <= 1'b0;
         nwords_q      <= '0;
         in_cmd_q      <= 1'b0;
         byte_q        <= '0;
         word_q        <= '0;
         wdata_q       <= '0;
         rx_sh_q       <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         status_q      <= '0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         ss_n_q        <= 1'b1;
      end else begin
         rdata_valid_q <= 1'b0;
         done_q        <= 1'b0;
         ss_n_q        <= ss_n_d;
         if (state_q == IDLE && i_cmd_valid) begin
            cmd_q      <= i_cmd;
            tx_words_q <= i_tx_words;
            nwords_q   <= sat_words(i_num_words, MAX_W);
            in_cmd_q   <= 1'b1;
            byte_q     <= '0;
            word_q     <= '0;
            busy_q     <= 1'b1;
         end
         if (state_q == FETCH && i_wdata_valid) wdata_q <= i_wdata;
         if (state_q == WAIT_RX && i_rx_valid) begin
            if (in_cmd_q) status_q <= i_rx_data;
            else begin
               rx_sh_q <= {i_rx_data, rx_sh_q[23:8]};
               if (byte_q == 2'd3) begin
                  rdata_q       <= {i_rx_data, rx_sh_q};
                  rdata_valid_q <= 1'b1;
               end
            end
         end
         if (state_q == HOLD && tmr_zero) begin
            if (last_byte) begin
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               in_cmd_q <= 1'b0;
            end else if (in_cmd_q) in_cmd_q <= 1'b0;
            else begin
               byte_q <= byte_q + 2'd1;
               if (byte_q == 2'd3) word_q <= word_q + 5'd1;
            end
         end
      end
   end

   assign o_cmd_ready   = (state_q == IDLE);
   assign o_wdata_ready = (state_q == FETCH);
   assign o_tx_valid    = (state_q == SEND) && i_tx_ready;
   assign o_tx_data     = in_cmd_q ? cmd_q : (tx_words_q ? wdata_q[{byte_q, 3'b000} +: 8] : 8'h00);
   assign o_ss_n        = ss_n_q;
   assign o_rdata       = rdata_q;
   assign o_rdata_valid = rdata_valid_q;
   assign o_status      = status_q;
   assign o_done        = done_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_spi_host_seq.sv
// tb_spi_host_seq: randomized bench with an spi_master/slave responder and a transaction-level reference model
module tb_spi_host_seq;
   import spi_pkg::*;

   localparam int SU_C = 10;
   localparam int HD_C = 10;
   localparam int MAXW = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  cmd = '0;
   logic [4:0]  num_words = '0;
   logic        tx_words = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] wdata;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic [7:0]  status;
   logic        done, busy;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        ss_n;

   always #5 clk = ~clk;

   spi_host_seq #(.CS_SETUP_CYC(SU_C), .CS_HOLD_CYC(HD_C), .MAX_WORDS(MAXW)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_cmd         (cmd),
      .i_num_words   (num_words),
      .i_tx_words    (tx_words),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_wdata       (wdata),
      .i_wdata_valid (wdata_valid),
      .o_wdata_ready (wdata_ready),
      .o_rdata       (rdata),
      .o_rdata_valid (rdata_valid),
      .o_status      (status),
      .o_done        (done),
      .o_busy        (busy),
      .o_tx_data     (tx_data),
      .o_tx_valid    (tx_valid),
      .i_tx_ready    (tx_ready),
      .i_rx_valid    (rx_valid),
      .i_rx_data     (rx_data),
      .o_ss_n        (ss_n)
   );

   int          n_tests = 0, n_fail = 0;
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_rd[$];
   logic [7:0]  tx_log[$];
   logic [31:0] rd_log[$];
   logic [31:0] wr_words[MAXW];
   logic [31:0] sl_words[MAXW];
   logic [7:0]  sl_status = '0;
   logic [7:0]  exp_status = '0;
   int          mst_idx = 0, wd_idx = 0, wd_fixed = -1;
   int          pulses = 0, exp_pulses = 0, done_cnt = 0, hc = 0, lc = 0;
   bit          cur_txw = 0, prev_ss = 1, prev_busy = 0, frame_tx = 0;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // slave reply for the k-th byte of a transaction: status for the command, then words LSB-first
   function automatic logic [7:0] reply(input int k);
      logic [31:0] w;
      if (k == 0) return sl_status;
      w = sl_words[(k - 1) / 4];
      return w[8 * ((k - 1) % 4) +: 8];
   endfunction

   task automatic rnd_words();
      for (int i = 0; i < MAXW; i++) begin
         wr_words[i] = $urandom;
         sl_words[i] = $urandom;
      end
      sl_status = 8'($urandom);
   endtask

   // reference model: expected byte stream and received words, then issue the command
   task automatic start_txn(input logic [7:0] c, input int n, input bit txw);
      int ns;
      logic [31:0] w;
      ns = (n > MAXW) ? MAXW : n;
      exp_tx.delete(); exp_rd.delete(); tx_log.delete(); rd_log.delete();
      exp_tx.push_back(c);
      for (int i = 0; i < ns; i++) begin
         w = wr_words[i];
         for (int b = 0; b < 4; b++) exp_tx.push_back(txw ? w[8*b +: 8] : 8'h00);
         exp_rd.push_back(sl_words[i]);
      end
      cur_txw = txw; exp_pulses = 1 + 4 * ns; exp_status = sl_status;
      pulses = 0; done_cnt = 0; mst_idx = 0; wd_idx = 0;
      @(negedge clk);
      cmd = c; num_words = 5'(n); tx_words = txw; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         cmd = 8'($urandom); num_words = 5'($urandom); tx_words = 1'($urandom);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic finish_txn(input string nm);
      for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
      chk(done_cnt > 0, {nm, "_done_timeout"}, 32'(done_cnt), 32'd1);
      repeat (5) @(negedge clk);
      chk(done_cnt == 1, {nm, "_done_count"}, 32'(done_cnt), 32'd1);
      chk(tx_log.size() == exp_tx.size(), {nm, "_tx_count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
      chk(rd_log.size() == exp_rd.size(), {nm, "_rd_count"}, 32'(rd_log.size()), 32'(exp_rd.size()));
      chk(pulses == exp_pulses, {nm, "_ss_pulses"}, 32'(pulses), 32'(exp_pulses));
      chk(status == exp_status, {nm, "_status"}, 32'(status), 32'(exp_status));
      chk(!busy && cmd_ready, {nm, "_idle_after"}, {busy, cmd_ready}, 32'h1);
   endtask

   // spi_master stand-in: takes a byte, drops ready, returns the slave reply, raises ready; injects stray rx pulses when idle
   initial begin
      tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
      forever begin
         @(negedge clk);
         rx_valid = 1'b0;
         if (rst_n && tx_valid) begin
            int k, lat, gap;
            k = mst_idx; mst_idx++;
            lat = $urandom_range(1, 6); gap = $urandom_range(0, 3);
            @(posedge clk);
            #1 tx_ready = 1'b0;
            repeat (lat) @(posedge clk);
            #1 begin rx_valid = 1'b1; rx_data = reply(k); end
            @(posedge clk);
            #1 begin rx_valid = 1'b0; rx_data = 8'($urandom); end
            repeat (gap) @(posedge clk);
            #1 tx_ready = 1'b1;
         end else if (rst_n && $urandom_range(0, 9) == 0) begin
            rx_valid = 1'b1; rx_data = 8'($urandom);
         end
      end
   end

   // word source: answers o_wdata_ready after a delay, checking the bus stays quiet meanwhile
   initial begin
      wdata = '0; wdata_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && wdata_ready) begin
            int d;
            d = (wd_fixed >= 0) ? wd_fixed : $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
               chk(ss_n && !tx_valid && wdata_ready, "fetch_wait", {ss_n, tx_valid, wdata_ready}, 32'h5);
               @(negedge clk);
            end
            wdata = wr_words[wd_idx]; wdata_valid = 1'b1;
            @(posedge clk);
            #1 begin wdata_valid = 1'b0; wdata = $urandom; wd_idx++; end
         end
      end
   end

   // compare process: checks every cycle against the model's byte stream, framing and timing rules
   always @(negedge clk) begin
      if (!rst_n) begin
         chk(ss_n && !tx_valid && !busy && !done && !rdata_valid && !wdata_ready, "reset_ctl",
             {ss_n, tx_valid, busy, done, rdata_valid, wdata_ready}, 32'h20);
         chk(rdata == 0 && status == 0 && tx_data == 0, "reset_data", rdata ^ {status, 16'h0, tx_data}, 32'h0);
         prev_ss = 1; prev_busy = 0; hc = 0;
      end else begin
         chk(cmd_ready == !busy, "cmd_ready", {cmd_ready, busy}, {busy, !busy});
         if (!ss_n) begin
            if (prev_ss) begin
               pulses++;
               if (pulses > 1) begin
                  if (cur_txw && (pulses - 2) % 4 == 0) chk(hc >= HD_C + 1, "hold_fetch_gap", 32'(hc), 32'(HD_C + 1));
                  else chk(hc == HD_C, "hold_gap", 32'(hc), 32'(HD_C));
               end
               lc = 0; frame_tx = 0;
            end
            lc++;
            chk(busy, "busy_while_ss", busy, 32'h1);
         end else begin
            if (!prev_ss) hc = 0;
            hc++;
         end
         if (tx_valid) begin
            chk(!ss_n, "tx_ss", ss_n, 32'h0);
            chk(lc == SU_C + 1, "setup_len", 32'(lc), 32'(SU_C + 1));
            chk(!frame_tx, "one_tx_per_frame", frame_tx, 32'h0);
            frame_tx = 1;
            if (tx_log.size() < exp_tx.size()) chk(tx_data == exp_tx[tx_log.size()], "tx_byte", tx_data, exp_tx[tx_log.size()]);
            else chk(0, "tx_extra", tx_data, 32'h0);
            tx_log.push_back(tx_data);
         end
         if (rdata_valid) begin
            if (rd_log.size() < exp_rd.size()) chk(rdata == exp_rd[rd_log.size()], "rdata", rdata, exp_rd[rd_log.size()]);
            else chk(0, "rdata_extra", rdata, 32'h0);
            rd_log.push_back(rdata);
         end
         if (done) begin
            chk(!busy && prev_busy, "done_busy_fall", {prev_busy, busy}, 32'h2);
            chk(hc == HD_C + 1, "done_timing", 32'(hc), 32'(HD_C + 1));
            done_cnt++;
         end
         if (wdata_ready) chk(ss_n && !tx_valid, "fetch_bus_quiet", {ss_n, tx_valid}, 32'h2);
         prev_ss = ss_n; prev_busy = busy;
      end
   end

   initial begin
      logic [7:0] lit40[9];
      int n;
      bit txw;
      lit40 = '{8'h01, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h18, 8'hFC, 8'hFF, 8'hFF};
      rnd_words();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk(cmd_ready && ss_n && status == 8'h00, "post_reset", {cmd_ready, ss_n, status}, 32'h300);

      wr_words[0] = 32'h0000000A; wr_words[1] = 32'hFFFFFC18;
      start_txn(CMD_WRITE_VALS, 2, 1'b1);
      finish_txn("write2");
      for (int i = 0; i < 9; i++) chk(tx_log[i] == lit40[i], "write2_lit_byte", tx_log[i], lit40[i]);
      chk(pulses == 9, "write2_lit_pulses", 32'(pulses), 32'd9);

      sl_status = 8'h01;
      start_txn(CMD_CHECK_DONE, 0, 1'b0);
      finish_txn("check_done");
      chk(status == 8'h01 && tx_log.size() == 1 && tx_log[0] == 8'h03, "check_done_lit",
          {status, 8'(tx_log.size()), tx_log[0]}, 32'h010103);

      for (int i = 0; i < MAXW; i++) sl_words[i] = 32'(i + 1);
      start_txn(CMD_READ_VALS, 20, 1'b0);
      finish_txn("read20");
      for (int i = 0; i < 20; i++) chk(rd_log[i] == 32'(i + 1), "read20_lit_word", rd_log[i], 32'(i + 1));
      for (int i = 1; i < 81; i++) chk(tx_log[i] == 8'h00, "read20_lit_zero", tx_log[i], 32'h0);

      rnd_words();
      start_txn(CMD_READ_RESULT1, 25, 1'b0);
      finish_txn("sat25");
      chk(rd_log.size() == 20 && tx_log.size() == 81, "sat25_lit", {16'(rd_log.size()), 16'(tx_log.size())}, 32'h00140051);

      rnd_words();
      wd_fixed = 50;
      start_txn(CMD_WRITE_VALS, 1, 1'b1);
      finish_txn("fetch_stall");
      wd_fixed = -1;

      rnd_words();
      start_txn(CMD_READ_RESULT2, 5, 1'b0);
      for (int i = 0; i < 20000 && tx_log.size() < 10; i++) begin
         @(negedge clk);
         #1;
      end
      chk(tx_log.size() == 10, "rst_reach_word3", 32'(tx_log.size()), 32'd10);
      @(posedge clk);
      #1 chk(!ss_n, "pre_rst_ss_low", ss_n, 32'h0);
      #1 rst_n = 1'b0;
      #1 chk(ss_n && !busy && !done && !rdata_valid, "async_rst", {ss_n, busy, done, rdata_valid}, 32'h8);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk(cmd_ready, "ready_after_rst", cmd_ready, 32'h1);
      repeat (30) @(negedge clk);
      chk(done_cnt == 0 && rd_log.size() == 2, "rst_abort", {16'(done_cnt), 16'(rd_log.size())}, 32'h2);
      start_txn(CMD_READ_VALS, 3, 1'b0);
      finish_txn("after_rst");

      for (int t = 0; t < 6; t++) begin
         rnd_words();
         n = (t == 3) ? $urandom_range(21, 31) : $urandom_range(0, 6);
         txw = 1'($urandom);
         start_txn(8'($urandom_range(1, 5)), n, txw);
         finish_txn("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1);
   end

endmodule

// File: doc/spi_host_seq.md
SPI_HOST_SEQ -- requirements
Module: spi_host_seq

Interface
REQ-001 The block SHALL have parameter CS_SETUP_CYC, default 10: i_clk cycles from o_ss_n low to the first o_tx_valid of a byte.
REQ-002 The block SHALL have parameter CS_HOLD_CYC, default 10: i_clk cycles o_ss_n stays high after a byte, before the next byte may start.
REQ-003 The block SHALL have parameter MAX_WORDS, default 20: maximum number of data words per transaction.
REQ-004 The block SHALL have one clock, i_clk; reset i_rst_n is asynchronous and active-low.
REQ-005 i_clk  in  1  system clock; all logic on the rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_cmd  in  8  command byte, sent first in a transaction.
REQ-008 i_num_words  in  5  number of 32-bit data words following the command.
REQ-009 i_tx_words  in  1  1: data bytes come from i_wdata; 0: data bytes are 8'h00.
REQ-010 i_cmd_valid / o_cmd_ready  in/out  1/1  transaction-start handshake.
REQ-011 i_wdata / i_wdata_valid / o_wdata_ready  in/in/out  32/1/1  transmit word handshake.
REQ-012 o_rdata / o_rdata_valid  out/out  32/1  received word plus a 1-cycle strobe.
REQ-013 o_status  out  8  byte received during the command byte.
REQ-014 o_done / o_busy  out/out  1/1  end-of-transaction pulse / transaction-in-progress level.
REQ-015 o_tx_data / o_tx_valid / i_tx_ready  out/out/in  8/1/1  byte interface to spi_master.
REQ-016 i_rx_valid / i_rx_data  in/in  1/8  received byte from spi_master.
REQ-017 o_ss_n  out  1  slave select to spi_to_hls, active-low.

Function
REQ-018 The state machine SHALL use the states IDLE, FETCH, SETUP, SEND, WAIT_RX, WAIT_RDY and HOLD.
REQ-019 In IDLE, o_cmd_ready SHALL be 1; on i_cmd_valid&&o_cmd_ready the block SHALL latch i_cmd, i_tx_words and min(i_num_words, MAX_WORDS), set o_busy, and go to SETUP.
REQ-020 Every byte, command or data, SHALL be framed individually: o_ss_n goes low on SETUP entry and stays low for CS_SETUP_CYC cycles.
REQ-021 SEND SHALL wait for i_tx_ready, then drive o_tx_valid high for exactly 1 cycle with o_tx_data stable.
REQ-022 WAIT_RX SHALL capture i_rx_data on the first i_rx_valid after o_tx_valid.
REQ-023 WAIT_RDY SHALL wait for i_tx_ready, after which o_ss_n goes high and the block enters HOLD for CS_HOLD_CYC cycles.
REQ-024 Byte order SHALL be command first, then each word LSB-first (bits [7:0], [15:8], [23:16], [31:24]).
REQ-025 When i_tx_words=1, the block SHALL enter FETCH before byte 0 of each word, assert o_wdata_ready, and register i_wdata on handshake; it waits indefinitely with o_ss_n high.
REQ-026 When i_tx_words=0, FETCH SHALL be skipped and the transmitted bytes SHALL be 8'h00.
REQ-027 The command-byte rx SHALL load o_status, which holds until the next command byte.
REQ-028 Rx bytes SHALL assemble LSB-first; after the 4th byte's capture, o_rdata SHALL update and o_rdata_valid SHALL pulse 1 cycle, including during writes.
REQ-029 After the last byte's HOLD, o_done SHALL pulse 1 cycle in the same cycle that o_busy falls; the block then returns to IDLE.
REQ-030 If i_num_words=0, the transaction SHALL be the command byte only.
REQ-031 i_num_words>MAX_WORDS SHALL saturate to MAX_WORDS.
REQ-032 i_cmd_valid outside IDLE SHALL be ignored (o_cmd_ready=0).
REQ-033 i_rx_valid outside WAIT_RX SHALL be ignored.
REQ-034 The word counter and byte counter SHALL each reset to 0 at transaction start.
REQ-035 Latency per byte SHALL be CS_SETUP_CYC + spi_master transfer time + CS_HOLD_CYC + 3 cycles of state overhead.

Reset
REQ-036 On i_rst_n low, the block SHALL immediately (asynchronously) force o_ss_n=1, state=IDLE, o_tx_valid=0, o_tx_data=0, o_rdata=0, o_rdata_valid=0, o_status=0, o_done=0, o_busy=0, o_wdata_ready=0 and all counters to 0.
REQ-037 Reset mid-transaction SHALL abort the transaction with no o_done and no partial o_rdata_valid; after release, o_cmd_ready=1 on the first clock.

Structure
REQ-038 A shared package spi_pkg SHALL hold the state enum and the command constants CMD_WRITE_VALS=8'h01, CMD_READ_VALS=8'h02, CMD_CHECK_DONE=8'h03, CMD_READ_RESULT1=8'h04 and CMD_READ_RESULT2=8'h05.
REQ-039 One sub-module, spi_seq_timer (a loadable down-counter for setup/hold delays), SHALL be used; there SHALL be no other hierarchy.

Verification
REQ-040 Bench: CMD_WRITE_VALS, num_words=2, tx_words=1, words 32'h0000000A, 32'hFFFFFC18 -> MOSI bytes 01,0A,00,00,00,18,FC,FF,FF; 9 o_ss_n low pulses; one o_done.
REQ-041 Bench: CMD_CHECK_DONE, num_words=0 -> a single framed byte; o_status equals the slave reply (bit0=1 when HLS done); o_done 1 cycle after HOLD.
REQ-042 Bench: CMD_READ_VALS, num_words=20, tx_words=0 against spi_to_hls preloaded with values 1..20 -> 20 o_rdata_valid pulses, o_rdata in sequence, all tx bytes 00.
REQ-043 Bench: num_words=25 -> exactly 20 words transferred.
REQ-044 Bench: i_wdata_valid withheld for 50 cycles in FETCH -> o_ss_n high throughout, no o_tx_valid; the transfer resumes on valid.
REQ-045 Bench: i_rst_n low during WAIT_RX of word 3 -> o_ss_n=1 asynchronously, no o_done; a following full transaction is correct.
